// File: rtl/modulation_settings_ctrl.sv
// Configuration sequencer for the modulation pipeline (timer / swapchain / multiplier).
// Latency: commit write at edge N with downstream idle -> UPDATE high in cycle N+3.
// Backpressure: waits in WAIT_READY while downstream_busy_i is high, aborts after TIMEOUT cycles.
module modulation_settings_ctrl #(
  parameter int unsigned MIN_FREQ_DIV = 512,
  parameter logic [7:0]  MAX_MODE     = 8'h04,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [15:0] wr_data_i,
  input  logic        downstream_busy_i,
  output logic        req_rd_segment_o,
  output logic [14:0] cycle_o,
  output logic [15:0] freq_div_o,
  output logic [15:0] rep_o,
  output logic [63:0] transition_o,
  output logic        update_o,
  output logic        busy_o,
  output logic [2:0]  err_o
);

  // One full settings bank; staging, shadow and active banks share this layout.
  typedef struct packed {
    logic        seg;
    logic [14:0] cycle;
    logic [15:0] freq_div;
    logic [15:0] rep;
    logic [63:0] transition;
  } mod_settings_t;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CHECK      = 2'd1,
    S_WAIT_READY = 2'd2,
    S_COMMIT     = 2'd3
  } state_t;

  // Register map.
  localparam logic [3:0] A_CTL      = 4'd0;
  localparam logic [3:0] A_SEG      = 4'd1;
  localparam logic [3:0] A_CYCLE    = 4'd2;
  localparam logic [3:0] A_FREQ_DIV = 4'd3;
  localparam logic [3:0] A_REP      = 4'd4;
  localparam logic [3:0] A_TR0      = 4'd5;
  localparam logic [3:0] A_TR1      = 4'd6;
  localparam logic [3:0] A_TR2      = 4'd7;
  localparam logic [3:0] A_TR3      = 4'd8;

  // Timeout counter is at least 17 bits so it can never wrap before reaching TIMEOUT.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 17) ? $clog2(TIMEOUT + 1) : 17;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [15:0] MIN_DIV = 16'(MIN_FREQ_DIV);

  // Reset contents: everything zero except the divider, which resets to its legal minimum.
  localparam mod_settings_t RESET_BANK = '{
    seg:        1'b0,
    cycle:      15'd0,
    freq_div:   MIN_DIV,
    rep:        16'd0,
    transition: 64'd0
  };

  mod_settings_t    staging_q, staging_d;
  mod_settings_t    shadow_q,  shadow_d;
  mod_settings_t    active_q,  active_d;
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       err_q,     err_d;
  logic             update_q,  update_d;

  logic             ctl_wr;
  logic             commit_req;
  logic             clear_req;
  logic [2:0]       err_set;
  logic [CNT_W-1:0] cnt_inc;
  logic             shadow_invalid;

  assign ctl_wr     = wr_en_i && (wr_addr_i == A_CTL);
  assign commit_req = ctl_wr && wr_data_i[0];
  assign clear_req  = ctl_wr && wr_data_i[1];
  assign cnt_inc    = cnt_q + CNT_ONE;

  // Validation is done on the shadow bank so staging writes mid-sequence cannot race the check.
  assign shadow_invalid = (shadow_q.freq_div < MIN_DIV) ||
                          (shadow_q.transition[63:56] > MAX_MODE);

  // Staging bank: CPU writes land here only; addresses 9..15 are ignored.
  always_comb begin
    staging_d = staging_q;
    if (wr_en_i) begin
      case (wr_addr_i)
        A_SEG:      staging_d.seg               = wr_data_i[0];
        A_CYCLE:    staging_d.cycle             = wr_data_i[14:0];
        A_FREQ_DIV: staging_d.freq_div          = wr_data_i;
        A_REP:      staging_d.rep               = wr_data_i;
        A_TR0:      staging_d.transition[15:0]  = wr_data_i;
        A_TR1:      staging_d.transition[31:16] = wr_data_i;
        A_TR2:      staging_d.transition[47:32] = wr_data_i;
        A_TR3:      staging_d.transition[63:48] = wr_data_i;
        default:    staging_d = staging_q;
      endcase
    end
  end

  // Sequencer next state: snapshot, validate, wait for downstream idle, load active bank.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    update_d = 1'b0;
    err_set  = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (commit_req) begin
          shadow_d = staging_q;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        if (shadow_invalid) begin
          err_set[0] = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT_READY;
        end
      end

      S_WAIT_READY: begin
        if (!downstream_busy_i) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            err_set[1] = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_COMMIT: begin
        active_d = shadow_q;
        update_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A commit request arriving mid-sequence is dropped and flagged; the in-flight one proceeds.
    if (commit_req && (state_q != S_IDLE)) begin
      err_set[2] = 1'b1;
    end
  end

  // Sticky error bits: clear applies first so an error raised in the same cycle survives.
  always_comb begin
    err_d = clear_req ? 3'b000 : err_q;
    err_d = err_d | err_set;
  end

  // State and bank registers; reset aborts any sequence without an UPDATE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      staging_q <= RESET_BANK;
      shadow_q  <= RESET_BANK;
      active_q  <= RESET_BANK;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 3'b000;
      update_q  <= 1'b0;
    end else begin
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      update_q  <= update_d;
    end
  end

  assign req_rd_segment_o = active_q.seg;
  assign cycle_o          = active_q.cycle;
  assign freq_div_o       = active_q.freq_div;
  assign rep_o            = active_q.rep;
  assign transition_o     = active_q.transition;
  assign update_o         = update_q;
  assign busy_o           = (state_q != S_IDLE);
  assign err_o            = err_q;

endmodule

// File: tb/tb_modulation_settings_ctrl.sv
// Directed bench for modulation_settings_ctrl (TIMEOUT shortened to 16).
module tb_modulation_settings_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        ds_busy;
  logic        seg_o;
  logic [14:0] cycle_o;
  logic [15:0] freq_div_o;
  logic [15:0] rep_o;
  logic [63:0] transition_o;
  logic        update_o;
  logic        busy_o;
  logic [2:0]  err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modulation_settings_ctrl #(
    .MIN_FREQ_DIV(512),
    .MAX_MODE    (8'h04),
    .TIMEOUT     (16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .wr_en_i           (wr_en),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .downstream_busy_i (ds_busy),
    .req_rd_segment_o  (seg_o),
    .cycle_o           (cycle_o),
    .freq_div_o        (freq_div_o),
    .rep_o             (rep_o),
    .transition_o      (transition_o),
    .update_o          (update_o),
    .busy_o            (busy_o),
    .err_o             (err_o)
  );

  // Called at a negedge: drives one write sampled at the next posedge, returns at the following negedge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 16'd0;
  endtask

  // Counts negedges until update_o is seen; cyc stays 0 if the bound expires.
  task automatic wait_update(input int max_cyc, output int cyc);
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (update_o === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'd0; ds_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL reset_update got=%0h exp=0", update_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
    checks++; if (err_o !== 3'b000) begin errors++; $display("FAIL reset_err got=%0h exp=0", err_o); end
    checks++; if (freq_div_o !== 16'd512) begin errors++; $display("FAIL reset_freq got=%0d exp=512", freq_div_o); end
    checks++; if (cycle_o !== 15'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", cycle_o); end
  endtask

  task automatic test_basic_commit;
    int c;
    wr(4'd2, 16'd4999);
    wr(4'd3, 16'd5120);
    wr(4'd8, 16'h0000);
    checks++; if (cycle_o !== 15'd0) begin errors++; $display("FAIL staging_isolated got=%0d exp=0", cycle_o); end
    wr(4'd0, 16'h0001);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_check got=%0h exp=1", busy_o); end
    wait_update(10, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", c); end
    checks++; if (cycle_o !== 15'd4999) begin errors++; $display("FAIL basic_cycle got=%0d exp=4999", cycle_o); end
    checks++; if (freq_div_o !== 16'd5120) begin errors++; $display("FAIL basic_freq got=%0d exp=5120", freq_div_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_upd got=%0h exp=0", busy_o); end
    @(negedge clk);
    checks++; if (update_o !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%0h exp=0", update_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%0h exp=0", busy_o); end
  endtask

  task automatic test_invalid;
    int c;
    wr(4'd3, 16'd100);
    wr(4'd0, 16'h0001);
    wait_update(6, c);
    checks++; if (c !== 0) begin errors++; $display("FAIL inv_no_update got=%0d exp=0", c); end
    checks++; if (err_o !== 3'b001) begin errors++; $display("FAIL inv_err got=%0h exp=1", err_o); end
    checks++; if (freq_div_o !== 16'd5120) begin errors++; $display("FAIL inv_active_kept got=%0d exp=5120", freq_div_o); end
    wr(4'd0, 16'h0002);
    checks++; if (err_o !== 3'b000) begin errors++; $display("FAIL inv_clear got=%0h exp=0", err_o); end
    // One below the minimum divider is still rejected.
    wr(4'd3, 16'd511);
    wr(4'd0, 16'h0001);
    wait_update(6, c);
    checks++; if (c !== 0 || err_o !== 3'b001) begin errors++; $display("FAIL inv_511 upd=%0d err=%0h exp upd=0 err=1", c, err_o); end
    wr(4'd0, 16'h0002);
  endtask

  task automatic test_edges;
    int c;
    wr(4'd1, 16'h0001);
    wr(4'd2, 16'd0);
    wr(4'd3, 16'd512);
    wr(4'd4, 16'hFFFF);
    wr(4'd5, 16'h1111);
    wr(4'd6, 16'h2222);
    wr(4'd7, 16'h3333);
    wr(4'd8, 16'h04AB);
    wr(4'd9, 16'hFFFF);
    wr(4'd0, 16'h0001);
    wait_update(10, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL edge_latency got=%0d exp=3", c); end
    checks++; if (cycle_o !== 15'd0 || rep_o !== 16'hFFFF || seg_o !== 1'b1) begin
      errors++; $display("FAIL edge_fields cycle=%0d rep=%0h seg=%0h exp 0 ffff 1", cycle_o, rep_o, seg_o); end
    checks++; if (freq_div_o !== 16'd512) begin errors++; $display("FAIL edge_freq got=%0d exp=512", freq_div_o); end
    checks++; if (transition_o !== 64'h04AB_3333_2222_1111) begin errors++; $display("FAIL edge_trans got=%0h exp=04ab333322221111", transition_o); end
    // Mode 5 exceeds MAX_MODE.
    wr(4'd8, 16'h05AB);
    wr(4'd0, 16'h0001);
    wait_update(6, c);
    checks++; if (c !== 0 || err_o !== 3'b001) begin errors++; $display("FAIL edge_mode5 upd=%0d err=%0h exp upd=0 err=1", c, err_o); end
    checks++; if (transition_o !== 64'h04AB_3333_2222_1111) begin errors++; $display("FAIL edge_mode5_kept got=%0h", transition_o); end
    wr(4'd0, 16'h0002);
    wr(4'd8, 16'h0000);
    wr(4'd3, 16'd5120);
    wr(4'd2, 16'd4999);
  endtask

  task automatic test_wait_ready;
    int c;
    int seen;
    ds_busy = 1'b1;
    wr(4'd0, 16'h0001);
    seen = 0;
    repeat (11) begin
      @(negedge clk);
      if (update_o === 1'b1) seen++;
    end
    ds_busy = 1'b0;
    wait_update(10, c);
    checks++; if (seen !== 0 || c !== 2) begin errors++; $display("FAIL wait_latency got=%0d exp=13 early=%0d", 11 + c, seen); end
    // Timeout: downstream never frees; abort after 16 cycles in WAIT_READY.
    ds_busy = 1'b1;
    wr(4'd0, 16'h0001);
    seen = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (update_o === 1'b1) seen++;
      if (i == 16) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL tmo_busy16 got=%0h exp=1", busy_o); end
      end
      if (i == 17) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL tmo_busy17 got=%0h exp=0", busy_o); end
      end
    end
    ds_busy = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL tmo_no_update got=%0d exp=0", seen); end
    checks++; if (err_o !== 3'b010) begin errors++; $display("FAIL tmo_err got=%0h exp=2", err_o); end
    wr(4'd0, 16'h0002);
  endtask

  task automatic test_back_to_back;
    int c;
    wr(4'd2, 16'd321);
    wr(4'd0, 16'h0001);
    wait_update(10, c);
    checks++; if (c !== 3 || cycle_o !== 15'd321) begin errors++; $display("FAIL b2b_first lat=%0d cycle=%0d exp 3 321", c, cycle_o); end
    wr(4'd0, 16'h0001);
    wait_update(10, c);
    checks++; if (c !== 3) begin errors++; $display("FAIL b2b_second got=%0d exp=3", c); end
    checks++; if (err_o !== 3'b000) begin errors++; $display("FAIL b2b_no_overrun got=%0h exp=0", err_o); end
  endtask

  task automatic test_overrun;
    int c;
    // Raise ERR[0] first so the combined clear+overrun write can be observed.
    wr(4'd3, 16'd100);
    wr(4'd0, 16'h0001);
    repeat (3) @(negedge clk);
    wr(4'd3, 16'd5120);
    wr(4'd2, 16'd1234);
    ds_busy = 1'b1;
    wr(4'd0, 16'h0001);
    wr(4'd2, 16'd7);
    wr(4'd0, 16'h0003);
    checks++; if (err_o !== 3'b100) begin errors++; $display("FAIL ovr_err got=%0h exp=4", err_o); end
    ds_busy = 1'b0;
    wait_update(10, c);
    checks++; if (c === 0 || cycle_o !== 15'd1234) begin errors++; $display("FAIL ovr_old_cycle upd=%0d cycle=%0d exp 1234", c, cycle_o); end
    @(negedge clk);
    wr(4'd0, 16'h0001);
    wait_update(10, c);
    checks++; if (c !== 3 || cycle_o !== 15'd7) begin errors++; $display("FAIL ovr_next_cycle lat=%0d cycle=%0d exp 3 7", c, cycle_o); end
  endtask

  task automatic test_reset_mid;
    int seen;
    ds_busy = 1'b1;
    wr(4'd0, 16'h0001);
    @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%0h exp=1", busy_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0 || update_o !== 1'b0 || err_o !== 3'b000) begin
      errors++; $display("FAIL rmid_ctrl busy=%0h upd=%0h err=%0h exp 0 0 0", busy_o, update_o, err_o); end
    checks++; if (freq_div_o !== 16'd512 || cycle_o !== 15'd0 || rep_o !== 16'd0 || transition_o !== 64'd0 || seg_o !== 1'b0) begin
      errors++; $display("FAIL rmid_active freq=%0d cycle=%0d rep=%0h tr=%0h seg=%0h", freq_div_o, cycle_o, rep_o, transition_o, seg_o); end
    @(negedge clk);
    rst = 1'b0;
    ds_busy = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (update_o === 1'b1) seen++;
    end
    checks++; if (seen !== 0 || busy_o !== 1'b0) begin errors++; $display("FAIL rmid_after upd=%0d busy=%0h exp 0 0", seen, busy_o); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_invalid();
    test_edges();
    test_wait_ready();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
